// File: rtl/nor_flash_pkg.sv
// Shared types and constants for the NOR flash pin-level responder.
package nor_flash_pkg;

    typedef enum logic [3:0] {
        ST_RST        = 4'd0,
        ST_RECOVER    = 4'd1,
        ST_READ       = 4'd2,
        ST_UNLK1      = 4'd3,
        ST_UNLK2      = 4'd4,
        ST_PROG_ADDR  = 4'd5,
        ST_PROG_BUSY  = 4'd6,
        ST_ER_UNLK0   = 4'd7,
        ST_ER_UNLK1   = 4'd8,
        ST_ER_UNLK2   = 4'd9,
        ST_ERASE_BUSY = 4'd10
    } state_e;

    // Source selected onto DATA_out.
    typedef enum logic [1:0] {
        OUT_ZERO   = 2'd0,
        OUT_ARRAY  = 2'd1,
        OUT_STATUS = 2'd2
    } out_sel_e;

    localparam logic [7:0] CMD_UNLK1 = 8'hAA;
    localparam logic [7:0] CMD_UNLK2 = 8'h55;
    localparam logic [7:0] CMD_PROG  = 8'hA0;
    localparam logic [7:0] CMD_ERASE = 8'h80;
    localparam logic [7:0] CMD_CHIP  = 8'h10;
    localparam logic [7:0] CMD_RESET = 8'hF0;

    localparam logic [11:0] U1_ADDR = 12'hAAA;
    localparam logic [11:0] U2_ADDR = 12'h555;

    // The array port is owned by the internal engine in these states.
    function automatic logic is_busy(input state_e s);
        return (s == ST_PROG_BUSY) || (s == ST_ERASE_BUSY);
    endfunction

    // States in which the part reports ready and accepts commands.
    function automatic logic is_ready(input state_e s);
        return (s == ST_READ)     || (s == ST_UNLK1)    || (s == ST_UNLK2) ||
               (s == ST_PROG_ADDR) || (s == ST_ER_UNLK0) || (s == ST_ER_UNLK1) ||
               (s == ST_ER_UNLK2);
    endfunction

endpackage

// File: rtl/nor_flash_array.sv
// Single-port synchronous-read byte array; contents survive every reset.
module nor_flash_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [0:(2**AW)-1];

    // Read-first port: rdata returns the pre-write contents of addr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/nor_flash_responder.sv
// Device side of the parallel NOR flash bus: command decode, program/erase
// engine, status polling and read data, over a small internal array.
module nor_flash_responder
    import nor_flash_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int PROG_CYC = 8,
    parameter int RH_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nMEMRST,
    input  logic        nBYTE,
    input  logic        nCE,
    input  logic        nWE,
    input  logic        nOE,
    input  logic [26:0] ADDR,
    input  logic [7:0]  DATA_in,
    output logic [7:0]  DATA_out,
    output logic        DATA_oe,
    output logic        RDY_BSY
);

    localparam int CNT_W = MEM_AW + 1;
    localparam logic [CNT_W-1:0] RH_LAST    = CNT_W'(RH_CYC - 1);
    localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYC - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'((2 ** MEM_AW) - 1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               nwe_prev_r;
    logic               oe_prev_r;
    logic               tog_r;
    logic               tog_nxt_s;
    logic [MEM_AW-1:0]  prog_addr_r;
    logic [7:0]         prog_data_r;
    logic               oe_r;
    logic               rdy_r;
    logic [7:0]         status_r;
    out_sel_e           out_sel_r;
    logic               dq7_s;

    logic               hold_rst_s;
    logic               wr_ev_s;
    logic               wr_u1_s;
    logic               wr_u2_s;
    logic               oe_act_s;

    logic [MEM_AW-1:0]  ram_addr_s;
    logic               ram_we_s;
    logic [7:0]         ram_wdata_s;
    logic [7:0]         ram_rdata_s;

    // Upper address bits alias onto the array and take no part in decode.
    logic               addr_unused_s;
    assign addr_unused_s = ^ADDR[26:12];

    assign hold_rst_s = rst | ~nMEMRST;
    // Write strobe is the nWE rising edge with the chip selected, byte mode only.
    assign wr_ev_s    = nWE & ~nwe_prev_r & ~nCE & ~nBYTE;
    assign wr_u1_s    = wr_ev_s && (ADDR[11:0] == U1_ADDR);
    assign wr_u2_s    = wr_ev_s && (ADDR[11:0] == U2_ADDR);
    assign oe_act_s   = ~nCE & ~nOE;
    assign tog_nxt_s  = tog_r ^ (oe_act_s & ~oe_prev_r);
    assign dq7_s      = (state_r == ST_PROG_BUSY) ? ~prog_data_r[7] : 1'b0;

    // Next-state decode for reset recovery, command unlock and busy phases.
    always_comb begin
        state_nxt_s = state_r;
        if (hold_rst_s) begin
            state_nxt_s = ST_RST;
        end else begin
            case (state_r)
                ST_RST: state_nxt_s = ST_RECOVER;
                ST_RECOVER: begin
                    if (cnt_r == RH_LAST) state_nxt_s = ST_READ;
                    else                  state_nxt_s = ST_RECOVER;
                end
                ST_READ: begin
                    if (wr_u1_s && (DATA_in == CMD_UNLK1)) state_nxt_s = ST_UNLK1;
                    else                                   state_nxt_s = ST_READ;
                end
                ST_UNLK1: begin
                    if (wr_u2_s && (DATA_in == CMD_UNLK2)) state_nxt_s = ST_UNLK2;
                    else if (wr_ev_s)                      state_nxt_s = ST_READ;
                    else                                   state_nxt_s = ST_UNLK1;
                end
                ST_UNLK2: begin
                    if (wr_u1_s && (DATA_in == CMD_PROG))       state_nxt_s = ST_PROG_ADDR;
                    else if (wr_u1_s && (DATA_in == CMD_ERASE)) state_nxt_s = ST_ER_UNLK0;
                    else if (wr_ev_s)                           state_nxt_s = ST_READ;
                    else                                        state_nxt_s = ST_UNLK2;
                end
                // Any data, including the reset opcode, is a legal program value here.
                ST_PROG_ADDR: begin
                    if (wr_ev_s) state_nxt_s = ST_PROG_BUSY;
                    else         state_nxt_s = ST_PROG_ADDR;
                end
                ST_ER_UNLK0: begin
                    if (wr_u1_s && (DATA_in == CMD_UNLK1)) state_nxt_s = ST_ER_UNLK1;
                    else if (wr_ev_s)                      state_nxt_s = ST_READ;
                    else                                   state_nxt_s = ST_ER_UNLK0;
                end
                ST_ER_UNLK1: begin
                    if (wr_u2_s && (DATA_in == CMD_UNLK2)) state_nxt_s = ST_ER_UNLK2;
                    else if (wr_ev_s)                      state_nxt_s = ST_READ;
                    else                                   state_nxt_s = ST_ER_UNLK1;
                end
                ST_ER_UNLK2: begin
                    if (wr_u1_s && (DATA_in == CMD_CHIP)) state_nxt_s = ST_ERASE_BUSY;
                    else if (wr_ev_s)                     state_nxt_s = ST_READ;
                    else                                  state_nxt_s = ST_ER_UNLK2;
                end
                ST_PROG_BUSY: begin
                    if (cnt_r == PROG_LAST) state_nxt_s = ST_READ;
                    else                    state_nxt_s = ST_PROG_BUSY;
                end
                ST_ERASE_BUSY: begin
                    if (cnt_r == ERASE_LAST) state_nxt_s = ST_READ;
                    else                     state_nxt_s = ST_ERASE_BUSY;
                end
                default: state_nxt_s = ST_RST;
            endcase
        end
    end

    // Array port steering: bus reads when idle, engine access while busy.
    always_comb begin
        ram_addr_s  = ADDR[MEM_AW-1:0];
        ram_we_s    = 1'b0;
        ram_wdata_s = 8'hFF;
        if (hold_rst_s) begin
            ram_we_s = 1'b0;
        end else if (state_r == ST_PROG_BUSY) begin
            // Old value is read back during the busy window, AND-merged on the last cycle.
            ram_addr_s  = prog_addr_r;
            ram_we_s    = (cnt_r == PROG_LAST);
            ram_wdata_s = ram_rdata_s & prog_data_r;
        end else if (state_r == ST_ERASE_BUSY) begin
            ram_addr_s  = cnt_r[MEM_AW-1:0];
            ram_we_s    = 1'b1;
            ram_wdata_s = 8'hFF;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // State register, phase counter (cleared on every state change) and bus history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RST;
            cnt_r      <= {CNT_W{1'b0}};
            nwe_prev_r <= 1'b1;
            oe_prev_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= (state_nxt_s != state_r) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            nwe_prev_r <= nWE;
            oe_prev_r  <= oe_act_s;
        end
    end

    // Capture the program target on the data write.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_addr_r <= {MEM_AW{1'b0}};
            prog_data_r <= 8'h00;
        end else if (!hold_rst_s && (state_r == ST_PROG_ADDR) && wr_ev_s) begin
            prog_addr_r <= ADDR[MEM_AW-1:0];
            prog_data_r <= DATA_in;
        end
    end

    // Registered bus outputs: output enable, ready, status byte and read mux select.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_r      <= 1'b0;
            rdy_r     <= 1'b0;
            tog_r     <= 1'b0;
            status_r  <= 8'h00;
            out_sel_r <= OUT_ZERO;
        end else begin
            oe_r  <= oe_act_s & nMEMRST;
            rdy_r <= is_ready(state_nxt_s);
            if (!nMEMRST) begin
                tog_r     <= 1'b0;
                status_r  <= 8'h00;
                out_sel_r <= OUT_ZERO;
            end else begin
                tog_r     <= tog_nxt_s;
                status_r  <= {dq7_s, tog_nxt_s, 6'b000000};
                out_sel_r <= is_busy(state_r) ? OUT_STATUS : OUT_ARRAY;
            end
        end
    end

    // Read data source select; every input to this mux is a flop.
    always_comb begin
        case (out_sel_r)
            OUT_ZERO:   DATA_out = 8'h00;
            OUT_ARRAY:  DATA_out = ram_rdata_s;
            OUT_STATUS: DATA_out = status_r;
            default:    DATA_out = 8'h00;
        endcase
    end

    assign DATA_oe = oe_r;
    assign RDY_BSY = rdy_r;

    nor_flash_array #(
        .AW(MEM_AW)
    ) u_array (
        .clk   (clk),
        .addr  (ram_addr_s),
        .we    (ram_we_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

endmodule

// File: tb/tb_nor_flash_responder.sv
// Scoreboard bench for nor_flash_responder: shadow array model plus
// expected-value queue for every read issued on the bus.
module tb_nor_flash_responder;

    localparam int MEM_AW   = 12;
    localparam int PROG_CYC = 8;
    localparam int RH_CYC   = 2;
    localparam int MEM_SZ   = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        rst, nMEMRST, nBYTE, nCE, nWE, nOE;
    logic [26:0] ADDR;
    logic [7:0]  DATA_in, DATA_out;
    logic        DATA_oe, RDY_BSY;

    int          n_run  = 0;
    int          n_fail = 0;
    int          cyc_n  = 0;
    logic [7:0]  mdl [0:MEM_SZ-1];
    logic [7:0]  exp_q [$];
    logic        tog_m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    nor_flash_responder #(
        .MEM_AW(MEM_AW), .PROG_CYC(PROG_CYC), .RH_CYC(RH_CYC)
    ) dut (
        .clk(clk), .rst(rst), .nMEMRST(nMEMRST), .nBYTE(nBYTE),
        .nCE(nCE), .nWE(nWE), .nOE(nOE), .ADDR(ADDR),
        .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe), .RDY_BSY(RDY_BSY)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        ADDR = {15'd0, a}; DATA_in = d; nCE = 1'b0; nWE = 1'b0;
        cyc();
        nWE = 1'b1;
        cyc();
        nCE = 1'b1;
    endtask

    // One read pulse: the DUT sees a read-enable assertion edge, so DQ6 flips.
    task automatic bus_read(input logic [11:0] a, output logic [7:0] d, output logic oe);
        ADDR = {15'd0, a}; nCE = 1'b0; nOE = 1'b0;
        cyc();
        d  = DATA_out;
        oe = DATA_oe;
        tog_m = ~tog_m;
        nCE = 1'b1; nOE = 1'b1;
        cyc();
    endtask

    task automatic do_program(input logic [11:0] a, input logic [7:0] d);
        bus_write(12'hAAA, 8'hAA);
        bus_write(12'h555, 8'h55);
        bus_write(12'hAAA, 8'hA0);
        bus_write(a, d);
    endtask

    task automatic do_erase_cmd();
        bus_write(12'hAAA, 8'hAA);
        bus_write(12'h555, 8'h55);
        bus_write(12'hAAA, 8'h80);
        bus_write(12'hAAA, 8'hAA);
        bus_write(12'h555, 8'h55);
        bus_write(12'hAAA, 8'h10);
    endtask

    task automatic wait_ready(output int dur);
        int t0;
        t0 = cyc_n;
        while (RDY_BSY !== 1'b1 && (cyc_n - t0) < 3 * MEM_SZ) cyc();
        dur = cyc_n - t0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; nMEMRST = 1'b1; nBYTE = 1'b0; nCE = 1'b1; nWE = 1'b1; nOE = 1'b1;
        ADDR = 27'd0; DATA_in = 8'h00;
        repeat (3) cyc();
        n_run++;
        if (DATA_out !== 8'h00 || DATA_oe !== 1'b0 || RDY_BSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: DATA_out=%h DATA_oe=%b RDY_BSY=%b, want 00/0/0", DATA_out, DATA_oe, RDY_BSY);
        end
        rst = 1'b0; nMEMRST = 1'b0; nCE = 1'b0; nOE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_run++;
            if (RDY_BSY !== 1'b0 || DATA_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL memrst_low[%0d]: RDY_BSY=%b DATA_oe=%b, want 0/0", i, RDY_BSY, DATA_oe);
            end
        end
        nCE = 1'b1; nOE = 1'b1; nMEMRST = 1'b1;
        n = 0;
        while (RDY_BSY !== 1'b1 && n < 20) begin cyc(); n++; end
        n_run++;
        if (n != RH_CYC + 1) begin
            n_fail++;
            $display("FAIL recover_len: ready after %0d edges, want %0d", n, RH_CYC + 1);
        end
        n_run++;
        if (DATA_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_idle: DATA_oe=%b, want 0", DATA_oe);
        end
        tog_m = 1'b0;
    endtask

    task automatic test_erase();
        logic [7:0] got, exp_v; logic oeg; int t0, rd_n, dur;
        logic [11:0] addrs [3];
        addrs[0] = 12'h000; addrs[1] = 12'h010; addrs[2] = 12'hFFF;
        do_erase_cmd();
        for (int i = 0; i < MEM_SZ; i++) mdl[i] = 8'hFF;
        t0 = cyc_n; rd_n = 0;
        while (RDY_BSY === 1'b0 && (cyc_n - t0) < MEM_SZ + 100) begin
            if (rd_n < 2) begin
                exp_q.push_back({1'b0, ~tog_m, 6'b000000});
                bus_read(12'h123, got, oeg);
                exp_v = exp_q.pop_front();
                n_run++;
                if (got !== exp_v || oeg !== 1'b1) begin
                    n_fail++;
                    $display("FAIL erase_status[%0d]: got %h oe=%b, want %h oe=1", rd_n, got, oeg, exp_v);
                end
                rd_n++;
            end else begin
                cyc();
            end
        end
        dur = cyc_n - t0;
        n_run++;
        if (dur != MEM_SZ) begin
            n_fail++;
            $display("FAIL erase_busy_len: %0d cycles, want %0d", dur, MEM_SZ);
        end
        foreach (addrs[i]) exp_q.push_back(mdl[addrs[i]]);
        foreach (addrs[i]) begin
            bus_read(addrs[i], got, oeg);
            exp_v = exp_q.pop_front();
            n_run++;
            if (got !== exp_v || oeg !== 1'b1) begin
                n_fail++;
                $display("FAIL erase_read@%h: got %h oe=%b, want %h", addrs[i], got, oeg, exp_v);
            end
        end
    endtask

    task automatic test_program();
        logic [7:0] got, exp_v; logic oeg; int t0, rd_n, dur;
        do_program(12'h010, 8'h3C);
        mdl[12'h010] = mdl[12'h010] & 8'h3C;
        t0 = cyc_n;
        n_run++;
        if (RDY_BSY !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_busy_fall: RDY_BSY=%b, want 0", RDY_BSY);
        end
        rd_n = 0;
        while (RDY_BSY === 1'b0 && (cyc_n - t0) < 4 * PROG_CYC) begin
            if (rd_n < 3) begin
                exp_q.push_back({1'b1, ~tog_m, 6'b000000});
                bus_read(12'h010, got, oeg);
                exp_v = exp_q.pop_front();
                n_run++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL prog_status[%0d]: got %h, want %h", rd_n, got, exp_v);
                end
                rd_n++;
            end else begin
                cyc();
            end
        end
        dur = cyc_n - t0;
        n_run++;
        if (dur != PROG_CYC) begin
            n_fail++;
            $display("FAIL prog_busy_len: %0d cycles, want %0d", dur, PROG_CYC);
        end
        exp_q.push_back(mdl[12'h010]);
        bus_read(12'h010, got, oeg);
        exp_v = exp_q.pop_front();
        n_run++;
        if (got !== exp_v || oeg !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_read: got %h oe=%b, want %h", got, oeg, exp_v);
        end
    endtask

    task automatic test_program_no_set();
        logic [7:0] got, exp_v; logic oeg; int dur;
        do_program(12'h010, 8'hF0);
        mdl[12'h010] = mdl[12'h010] & 8'hF0;
        wait_ready(dur);
        exp_q.push_back(mdl[12'h010]);
        bus_read(12'h010, got, oeg);
        exp_v = exp_q.pop_front();
        n_run++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL prog_and: got %h, want %h", got, exp_v);
        end
    endtask

    task automatic test_bad_unlock();
        logic [7:0] got, exp_v; logic oeg;
        bus_write(12'hAAA, 8'hAA);
        bus_write(12'h555, 8'h56);
        bus_write(12'hAAA, 8'hA0);
        bus_write(12'h010, 8'h00);
        cyc();
        n_run++;
        if (RDY_BSY !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_unlock_rdy: RDY_BSY=%b, want 1", RDY_BSY);
        end
        nBYTE = 1'b1;
        do_program(12'h010, 8'h00);
        nBYTE = 1'b0;
        cyc();
        n_run++;
        if (RDY_BSY !== 1'b1) begin
            n_fail++;
            $display("FAIL nbyte_rdy: RDY_BSY=%b, want 1", RDY_BSY);
        end
        exp_q.push_back(mdl[12'h010]);
        bus_read(12'h010, got, oeg);
        exp_v = exp_q.pop_front();
        n_run++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL bad_unlock_read: got %h, want %h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp_v; logic oeg; int dur;
        logic [11:0] addrs [2];
        addrs[0] = 12'h020; addrs[1] = 12'h021;
        do_program(12'h020, 8'h0F);
        mdl[12'h020] = mdl[12'h020] & 8'h0F;
        wait_ready(dur);
        n_run++;
        if (dur != PROG_CYC) begin
            n_fail++;
            $display("FAIL b2b_len0: %0d cycles, want %0d", dur, PROG_CYC);
        end
        do_program(12'h021, 8'hF3);
        mdl[12'h021] = mdl[12'h021] & 8'hF3;
        wait_ready(dur);
        n_run++;
        if (dur != PROG_CYC) begin
            n_fail++;
            $display("FAIL b2b_len1: %0d cycles, want %0d", dur, PROG_CYC);
        end
        foreach (addrs[i]) exp_q.push_back(mdl[addrs[i]]);
        foreach (addrs[i]) begin
            bus_read(addrs[i], got, oeg);
            exp_v = exp_q.pop_front();
            n_run++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_read@%h: got %h, want %h", addrs[i], got, exp_v);
            end
        end
    endtask

    task automatic test_erase_abort();
        logic [7:0] got, exp_v; logic oeg; int t0, n, dur;
        logic [11:0] addrs [5];
        addrs[0] = 12'h000; addrs[1] = 12'h010; addrs[2] = 12'h050;
        addrs[3] = 12'h0C8; addrs[4] = 12'h800;
        do_program(12'h800, 8'h5A);
        mdl[12'h800] = mdl[12'h800] & 8'h5A;
        wait_ready(dur);
        do_program(12'h0C8, 8'h12);
        mdl[12'h0C8] = mdl[12'h0C8] & 8'h12;
        wait_ready(dur);
        do_erase_cmd();
        t0 = cyc_n;
        while (RDY_BSY === 1'b0 && (cyc_n - t0) < 100) cyc();
        n_run++;
        if (RDY_BSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_still_busy: RDY_BSY=%b, want 0", RDY_BSY);
        end
        nMEMRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_run++;
            if (RDY_BSY !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_rst[%0d]: RDY_BSY=%b, want 0", i, RDY_BSY);
            end
        end
        nMEMRST = 1'b1;
        n = 0;
        while (RDY_BSY !== 1'b1 && n < 20) begin cyc(); n++; end
        n_run++;
        if (n != RH_CYC + 1) begin
            n_fail++;
            $display("FAIL abort_recover_len: ready after %0d edges, want %0d", n, RH_CYC + 1);
        end
        tog_m = 1'b0;
        for (int i = 0; i < 90; i++) mdl[i] = 8'hFF;
        foreach (addrs[i]) exp_q.push_back(mdl[addrs[i]]);
        foreach (addrs[i]) begin
            bus_read(addrs[i], got, oeg);
            exp_v = exp_q.pop_front();
            n_run++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL abort_read@%h: got %h, want %h", addrs[i], got, exp_v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_erase();
        test_program();
        test_program_no_set();
        test_bad_unlock();
        test_back_to_back();
        test_erase_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_flash_responder.md
# nor_flash_responder

Clocked, synthesizable responder for the parallel NOR flash pins: the device side of the flash interface our controller drives. It decodes nCE/nWE/nOE/ADDR/DATA, implements reset recovery, JEDEC unlock, byte-program and chip-erase sequences over a small internal array, and drives RDY_BSY and read data. It sits on the bench and FPGA test builds opposite the flash controller, so controller firmware and RTL can be exercised without a real part.

## Interface
- MEM_AW, 12: internal array address width (2^MEM_AW bytes); ADDR[MEM_AW-1:0] selects the byte, upper bits alias.
- PROG_CYC, 8: busy cycles per byte program.
- RH_CYC, 2: busy cycles after nMEMRST rises (or after rst) before commands are accepted.
- clk  in  1  system clock; all inputs are sampled on its rising edge, same domain as the controller, no synchronizers.
- rst  in  1  reset, synchronous, active-high.
- nMEMRST  in  1  device reset pin, active-low.
- nBYTE  in  1  bus width select; only byte mode (0) is supported.
- nCE  in  1  chip enable, active-low.
- nWE  in  1  write enable, active-low.
- nOE  in  1  output enable, active-low.
- ADDR  in  27  byte address.
- DATA_in  in  8  write data from the bus.
- DATA_out  out  8  read data to the bus.
- DATA_oe  out  1  tristate enable for DATA_out.
- RDY_BSY  out  1  1 = ready, 0 = busy or in reset.

## Operation
- Write event: a cycle where sampled nWE is 1, previous sampled nWE was 0, and sampled nCE is 0. ADDR and DATA_in are taken from that same cycle, so the controller holds them through the nWE rise edge.
- Unlock address match uses ADDR[11:0] only: U1 = 0xAAA, U2 = 0x555.
- States: RST, RECOVER, READ, UNLK1, UNLK2, PROG_ADDR, PROG_BUSY, ER_UNLK0, ER_UNLK1, ER_UNLK2, ERASE_BUSY.
- RST: entered on rst or sampled nMEMRST = 0, from any state. Leaves to RECOVER when nMEMRST = 1 and rst = 0.
- RECOVER: counts RH_CYC cycles, then goes to READ.
- READ: write (U1, 0xAA) goes to UNLK1.
- UNLK1: write (U2, 0x55) goes to UNLK2.
- UNLK2: write (U1, 0xA0) goes to PROG_ADDR; write (U1, 0x80) goes to ER_UNLK0.
- PROG_ADDR: the next write (any address) latches addr/data and goes to PROG_BUSY.
- ER_UNLK0: write (U1, 0xAA) goes to ER_UNLK1.
- ER_UNLK1: write (U2, 0x55) goes to ER_UNLK2.
- ER_UNLK2: write (U1, 0x10) goes to ERASE_BUSY.
- In any command state, a write with data 0xF0 or any non-matching write returns to READ with no array change.
- Writes during PROG_BUSY, ERASE_BUSY, RST and RECOVER are ignored.
- Program: the stored value becomes old & data, so bits only go 1→0, never 0→1. It is written in the last PROG_BUSY cycle, then the state returns to READ.
- Erase: writes 0xFF to addresses 0 .. 2^MEM_AW−1, one per cycle, then returns to READ.
- Read data while not busy: array[ADDR[MEM_AW-1:0]].
- Read data while busy is a status byte:
  - DQ7: ~programmed_data[7] during program, 0 during erase.
  - DQ6: toggles on each read-enable assertion edge.
  - Other bits: 0.
- nBYTE = 1: writes are ignored; reads behave as byte mode.
- Mid-operation abort: rst or nMEMRST low during a busy state goes to RST. The program is dropped. An erase leaves already-cleared bytes cleared. The array is never cleared by reset.

## Timing
- Reset values: DATA_out = 0x00, DATA_oe = 0, RDY_BSY = 0, state RST, DQ6 toggle bit = 0.
- DATA_oe is registered: 1 the cycle after sampled nCE = 0, nOE = 0, nMEMRST = 1 and rst = 0.
- DATA_out is registered: it reflects the ADDR sampled one cycle earlier, so read latency is 1 cycle.
- RDY_BSY is registered and is 0 in RST, RECOVER, PROG_BUSY and ERASE_BUSY.
- RDY_BSY rises exactly RH_CYC cycles after the first RECOVER cycle.
- Program: RDY_BSY falls the cycle after the data write event and stays low PROG_CYC cycles.
- Erase: RDY_BSY stays low for 2^MEM_AW cycles.
- A write event in the same cycle that busy ends is ignored; the first accepted write is on the cycle after RDY_BSY reads 1.

## Structure
- Package nor_flash_pkg holds:
  - the state enum;
  - command constants CMD_UNLK1 = 0xAA, CMD_UNLK2 = 0x55, CMD_PROG = 0xA0, CMD_ERASE = 0x80, CMD_CHIP = 0x10, CMD_RESET = 0xF0;
  - unlock addresses U1_ADDR = 12'hAAA and U2_ADDR = 12'h555.
- Sub-module nor_flash_array: single-port synchronous-read RAM, 2^MEM_AW × 8. It is not reset.

## Test plan
- rst, then nMEMRST held low 10 cycles, then high → RDY_BSY = 0 throughout, then 1 exactly RH_CYC (2) cycles after RECOVER entry; DATA_oe = 0 until nOE/nCE are low.
- Unlock plus program 0x3C at 0x010, then read 0x010 → RDY_BSY low 8 cycles; during busy DATA_out[7] = 1 and DQ6 alternates per read; after busy the read returns 0x3C.
- Program 0xF0 over stored 0x3C at 0x010 → read returns 0x30; bits do not set.
- Chip erase sequence → RDY_BSY low 4096 cycles; reads of 0x000, 0x010 and 0xFFF return 0xFF.
- Unlock, then bad second cycle (U2, 0x56), then program attempt → state back to READ; the following data write does not change the array.
- Erase in progress, nMEMRST pulsed low at cycle 100 → RDY_BSY = 0, RECOVER, then ready; addresses 0..~99 read 0xFF and higher addresses keep their old data.
